lstm_mem_dma: RTL and testbench
===============================

# lstm_mem_dma

Word-serial transfer engine that executes the jobs posted by the control sequencer (`start`, `direct`, `main_mem_count`, `main_mem_first_address`). It sits between main memory and the LSTM accelerator's local buffer. It copies `main_mem_count` words in the requested direction, then reports completion. It is the only master of both memory ports during a transfer.

## Interface
Parameters:
- `MAIN_MEM_ADD_LEN`, 11: main memory address width; also the width of the job count.
- `LSTM_ADD_LEN`, 7: LSTM buffer address width.
- `DATA_W`, 8: word width.

Ports:
- `fpga_clk` input 1: single clock; all logic is on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle job request.
- `direct` input 1: 0 = main memory to LSTM, 1 = LSTM to main memory.
- `main_mem_count` input MAIN_MEM_ADD_LEN: number of words to move.
- `main_mem_first_address` input MAIN_MEM_ADD_LEN: first main memory address.
- `mm_addr` output MAIN_MEM_ADD_LEN: main memory address.
- `mm_rd_en` output 1: main memory read strobe; read data is returned 1 cycle later.
- `mm_wr_en` output 1: main memory write strobe.
- `mm_wdata` output DATA_W: main memory write data.
- `mm_rdata` input DATA_W: main memory read data.
- `lstm_addr` output LSTM_ADD_LEN: LSTM buffer address.
- `lstm_rd_en` output 1: LSTM buffer read strobe; read data is returned 1 cycle after acceptance.
- `lstm_wr_en` output 1: LSTM buffer write strobe.
- `lstm_wdata` output DATA_W: LSTM buffer write data.
- `lstm_rdata` input DATA_W: LSTM buffer read data.
- `lstm_ready` input 1: LSTM port accepts the current rd/wr when high.
- `busy` output 1: a transfer is in progress.
- `done` output 1: one-cycle completion pulse.
- `err` output 1: sticky error flag; present only with `LSTM_DMA_ERR_CHECK_EN`.

## Operation
FSM states: IDLE, RD, LAT, WR, DONE.

- **IDLE**
  - `start`=1 latches `direct`, the count, and `main_mem_first_address`.
  - The LSTM address counter loads 0.
  - Next state is RD, or DONE if the count is 0.
- **RD**
  - Asserts the source read strobe at the source address.
  - If the source is main memory, advance to LAT unconditionally.
  - If the source is LSTM, wait in RD until `lstm_ready`=1, then advance.
- **LAT**
  - Captures source rdata into `data_q`.
  - Next state is WR.
- **WR**
  - Asserts the destination write strobe with wdata = `data_q`.
  - Main memory destination: the write completes immediately.
  - LSTM destination: hold in WR until `lstm_ready`=1.
  - On completion, increment both addresses and decrement the remaining count.
  - Go to RD if words remain, otherwise to DONE.
- **DONE**
  - `done`=1 for exactly one cycle, then IDLE.

Address rules:
- `mm_addr` wraps modulo 2^MAIN_MEM_ADD_LEN.
- `lstm_addr` wraps modulo 2^LSTM_ADD_LEN.

Strobe rules:
- Strobes and addresses are decoded from registered state and counters only; there is no combinational path from inputs to outputs.
- Only the strobes of the active state are high. Never more than one strobe is high per port.
- The unused direction's strobes stay 0.

Input rules:
- `start` outside IDLE (RD/LAT/WR/DONE) is ignored; the job in flight is unaffected.
- Job inputs are sampled only on the accepting edge.

Reset:
- Reset at any time abandons the transfer.
- All outputs, addresses, wdata, `busy`, `done`, and `err` reset to 0.
- The FSM resets to IDLE.

## Timing
- `start` is accepted at edge k.
- `busy`=1 from cycle k+1 through the last WR cycle; it is 0 in IDLE and DONE.
- With no stalls, n words take 3n cycles; `done` is high in cycle k+3n+1.
- For n=0, `done` is high in cycle k+1 and no strobes are issued.
- Each cycle of `lstm_ready`=0 during an LSTM RD or WR adds exactly one cycle.
- The next `start` can be accepted in the cycle after `done`.

## Configuration
`LSTM_DMA_ERR_CHECK_EN`:
- **Defined:** `err` sets, and stays set until reset, on either condition:
  - `start` is seen while not in IDLE;
  - an accepted job has first_address + count > 2^MAIN_MEM_ADD_LEN, or count > 2^LSTM_ADD_LEN.
  - The transfer still runs, with wrapping addresses.
- **Undefined:** the `err` port and its logic are absent; behaviour is otherwise identical.

## Structure
- `lstm_dma_pkg` holds:
  - the state enum type;
  - `DIR_M2L`=1'b0 and `DIR_L2M`=1'b1.
- One sub-module, `lstm_dma_addr_gen`, holds:
  - the main memory address counter, LSTM address counter, and remaining-count counter;
  - load, step, and last-word indication.

## Test plan
- M2L job: count=4, first=40, mm[40..43]=A1,B2,C3,D4, `lstm_ready`=1 → lstm[0..3]=A1,B2,C3,D4; `done` 13 cycles after the start edge; `busy` high 12 cycles.
- L2M job: count=4, first=168, lstm[0..3]=11,22,33,44 → mm[168..171]=11,22,33,44; `lstm_rd_en` high in 4 RD cycles.
- Backpressure: M2L count=2 with `lstm_ready` low for 3 cycles in the first WR → data intact; `done` at cycle k+10.
- count=0 → `done` at k+1; no strobes; `busy` stays 0.
- Wrap: first=2046, count=4 → mm reads at 2046, 2047, 0, 1; `err`=1 only with the macro defined.
- `start` mid-transfer, then `reset_n` low mid-transfer → the first is ignored; after reset all outputs are 0 and a new job runs correctly.

Source files
------------

// File: rtl/lstm_dma_pkg.sv
// Shared types and constants for the LSTM memory DMA engine.
// Optional feature macro used by this block: LSTM_DMA_ERR_CHECK_EN.
package lstm_dma_pkg;

    // Transfer engine states: one word moves as RD -> LAT -> WR.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_LAT  = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } dma_state_t;

    // Transfer direction encoding for the direct input.
    localparam logic DIR_M2L = 1'b0;
    localparam logic DIR_L2M = 1'b1;

endpackage

// File: rtl/lstm_dma_addr_gen.sv
// Address and word-count bookkeeping for the LSTM memory DMA engine.
// Holds the main memory address, LSTM buffer address and remaining-word
// counters; both addresses wrap naturally at their own widths.
module lstm_dma_addr_gen #(
    parameter int MAIN_MEM_ADD_LEN = 11,
    parameter int LSTM_ADD_LEN     = 7
) (
    input  logic                        fpga_clk,
    input  logic                        reset_n,
    input  logic                        load,
    input  logic                        step,
    input  logic [MAIN_MEM_ADD_LEN-1:0] first_address,
    input  logic [MAIN_MEM_ADD_LEN-1:0] count,
    output logic [MAIN_MEM_ADD_LEN-1:0] mm_addr,
    output logic [LSTM_ADD_LEN-1:0]     lstm_addr,
    output logic                        last_word
);

    localparam logic [MAIN_MEM_ADD_LEN-1:0] MM_ONE   = {{(MAIN_MEM_ADD_LEN-1){1'b0}}, 1'b1};
    localparam logic [LSTM_ADD_LEN-1:0]     LSTM_ONE = {{(LSTM_ADD_LEN-1){1'b0}}, 1'b1};

    logic [MAIN_MEM_ADD_LEN-1:0] mm_addr_reg;
    logic [MAIN_MEM_ADD_LEN-1:0] remaining_reg;
    logic [LSTM_ADD_LEN-1:0]     lstm_addr_reg;

    // Load a new job, or advance one word after each completed write.
    always_ff @(posedge fpga_clk or negedge reset_n) begin
        if (!reset_n) begin
            mm_addr_reg   <= '0;
            lstm_addr_reg <= '0;
            remaining_reg <= '0;
        end else if (load) begin
            mm_addr_reg   <= first_address;
            lstm_addr_reg <= '0;
            remaining_reg <= count;
        end else if (step) begin
            mm_addr_reg   <= mm_addr_reg + MM_ONE;
            lstm_addr_reg <= lstm_addr_reg + LSTM_ONE;
            remaining_reg <= remaining_reg - MM_ONE;
        end
    end

    assign mm_addr   = mm_addr_reg;
    assign lstm_addr = lstm_addr_reg;
    assign last_word = (remaining_reg == MM_ONE);

endmodule

// File: rtl/lstm_mem_dma.sv
// Word-serial DMA between main memory and the LSTM local buffer.
// Each word is read from the source, captured one cycle later, then written
// to the destination; LSTM-side accesses stall on lstm_ready.
// Optional macro LSTM_DMA_ERR_CHECK_EN adds a sticky err output flagging
// start while busy and jobs that overrun either address space.
module lstm_mem_dma
    import lstm_dma_pkg::*;
#(
    parameter int MAIN_MEM_ADD_LEN = 11,
    parameter int LSTM_ADD_LEN     = 7,
    parameter int DATA_W           = 8
) (
    input  logic                        fpga_clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic                        direct,
    input  logic [MAIN_MEM_ADD_LEN-1:0] main_mem_count,
    input  logic [MAIN_MEM_ADD_LEN-1:0] main_mem_first_address,
    output logic [MAIN_MEM_ADD_LEN-1:0] mm_addr,
    output logic                        mm_rd_en,
    output logic                        mm_wr_en,
    output logic [DATA_W-1:0]           mm_wdata,
    input  logic [DATA_W-1:0]           mm_rdata,
    output logic [LSTM_ADD_LEN-1:0]     lstm_addr,
    output logic                        lstm_rd_en,
    output logic                        lstm_wr_en,
    output logic [DATA_W-1:0]           lstm_wdata,
    input  logic [DATA_W-1:0]           lstm_rdata,
    input  logic                        lstm_ready,
    output logic                        busy,
    output logic                        done
`ifdef LSTM_DMA_ERR_CHECK_EN
    ,
    output logic                        err
`endif
);

    dma_state_t        state_reg;
    logic              dir_reg;
    logic [DATA_W-1:0] data_reg;
    logic              load;
    logic              step;
    logic              last_word;

    // A job is taken only from IDLE; a word completes when the destination accepts.
    assign load = (state_reg == ST_IDLE) && start;
    assign step = (state_reg == ST_WR) && ((dir_reg == DIR_L2M) || lstm_ready);

    lstm_dma_addr_gen #(
        .MAIN_MEM_ADD_LEN (MAIN_MEM_ADD_LEN),
        .LSTM_ADD_LEN     (LSTM_ADD_LEN)
    ) u_addr_gen (
        .fpga_clk      (fpga_clk),
        .reset_n       (reset_n),
        .load          (load),
        .step          (step),
        .first_address (main_mem_first_address),
        .count         (main_mem_count),
        .mm_addr       (mm_addr),
        .lstm_addr     (lstm_addr),
        .last_word     (last_word)
    );

    // Transfer sequencer: direction latch, word capture and state progression.
    always_ff @(posedge fpga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            dir_reg   <= DIR_M2L;
            data_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        dir_reg   <= direct;
                        state_reg <= (main_mem_count == '0) ? ST_DONE : ST_RD;
                    end
                end
                ST_RD: begin
                    // Main memory always accepts; the LSTM port may stall the read.
                    if ((dir_reg == DIR_M2L) || lstm_ready) begin
                        state_reg <= ST_LAT;
                    end
                end
                ST_LAT: begin
                    data_reg  <= (dir_reg == DIR_M2L) ? mm_rdata : lstm_rdata;
                    state_reg <= ST_WR;
                end
                ST_WR: begin
                    if (step) begin
                        state_reg <= last_word ? ST_DONE : ST_RD;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Port strobes are pure decodes of the registered state and direction.
    assign mm_rd_en   = (state_reg == ST_RD) && (dir_reg == DIR_M2L);
    assign lstm_rd_en = (state_reg == ST_RD) && (dir_reg == DIR_L2M);
    assign mm_wr_en   = (state_reg == ST_WR) && (dir_reg == DIR_L2M);
    assign lstm_wr_en = (state_reg == ST_WR) && (dir_reg == DIR_M2L);
    assign mm_wdata   = data_reg;
    assign lstm_wdata = data_reg;
    assign busy       = (state_reg == ST_RD) || (state_reg == ST_LAT) || (state_reg == ST_WR);
    assign done       = (state_reg == ST_DONE);

`ifdef LSTM_DMA_ERR_CHECK_EN
    localparam logic [MAIN_MEM_ADD_LEN:0] MM_SPAN   = {1'b1, {MAIN_MEM_ADD_LEN{1'b0}}};
    localparam logic [MAIN_MEM_ADD_LEN:0] LSTM_SPAN = (MAIN_MEM_ADD_LEN+1)'(2 ** LSTM_ADD_LEN);

    logic                      err_reg;
    logic [MAIN_MEM_ADD_LEN:0] job_end;

    assign job_end = {1'b0, main_mem_first_address} + {1'b0, main_mem_count};

    // Sticky error: start while busy, or an accepted job overrunning either memory.
    always_ff @(posedge fpga_clk or negedge reset_n) begin
        if (!reset_n) begin
            err_reg <= 1'b0;
        end else if (start && (state_reg != ST_IDLE)) begin
            err_reg <= 1'b1;
        end else if (load && ((job_end > MM_SPAN) || ({1'b0, main_mem_count} > LSTM_SPAN))) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`endif

endmodule

// File: tb/tb_lstm_mem_dma.sv
// Self-checking bench for lstm_mem_dma: table-driven directed jobs, hand
// sequences for reset and mid-transfer start, and randomized jobs checked
// against a word-copy reference model of both memories.
module tb_lstm_mem_dma;
    import lstm_dma_pkg::*;

    localparam int MW = 11;
    localparam int LW = 7;
    localparam int DW = 8;
    localparam int MM_DEPTH = 2 ** MW;
    localparam int LSTM_DEPTH = 2 ** LW;

    logic          fpga_clk = 1'b0;
    logic          reset_n  = 1'b0;
    logic          start = 1'b0;
    logic          direct = 1'b0;
    logic [MW-1:0] main_mem_count = '0;
    logic [MW-1:0] main_mem_first_address = '0;
    logic [MW-1:0] mm_addr;
    logic          mm_rd_en, mm_wr_en;
    logic [DW-1:0] mm_wdata;
    logic [DW-1:0] mm_rdata = '0;
    logic [LW-1:0] lstm_addr;
    logic          lstm_rd_en, lstm_wr_en;
    logic [DW-1:0] lstm_wdata;
    logic [DW-1:0] lstm_rdata = '0;
    logic          lstm_ready = 1'b1;
    logic          busy, done;
`ifdef LSTM_DMA_ERR_CHECK_EN
    logic          err;
`endif

    lstm_mem_dma dut (
        .fpga_clk               (fpga_clk),
        .reset_n                (reset_n),
        .start                  (start),
        .direct                 (direct),
        .main_mem_count         (main_mem_count),
        .main_mem_first_address (main_mem_first_address),
        .mm_addr                (mm_addr),
        .mm_rd_en               (mm_rd_en),
        .mm_wr_en               (mm_wr_en),
        .mm_wdata               (mm_wdata),
        .mm_rdata               (mm_rdata),
        .lstm_addr              (lstm_addr),
        .lstm_rd_en             (lstm_rd_en),
        .lstm_wr_en             (lstm_wr_en),
        .lstm_wdata             (lstm_wdata),
        .lstm_rdata             (lstm_rdata),
        .lstm_ready             (lstm_ready),
        .busy                   (busy),
        .done                   (done)
`ifdef LSTM_DMA_ERR_CHECK_EN
        ,
        .err                    (err)
`endif
    );

    always #5 fpga_clk = ~fpga_clk;

    // Memories seen by the DUT, and the reference copies the model updates.
    logic [DW-1:0] mm_mem   [MM_DEPTH];
    logic [DW-1:0] lstm_mem [LSTM_DEPTH];
    logic [DW-1:0] mm_ref   [MM_DEPTH];
    logic [DW-1:0] lstm_ref [LSTM_DEPTH];
    logic [MW-1:0] addr_q[$];

    always @(posedge fpga_clk) begin
        if (mm_rd_en) mm_rdata <= mm_mem[mm_addr];
        if (mm_wr_en) mm_mem[mm_addr] <= mm_wdata;
        if (lstm_ready && lstm_rd_en) lstm_rdata <= lstm_mem[lstm_addr];
        if (lstm_ready && lstm_wr_en) lstm_mem[lstm_addr] <= lstm_wdata;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input longint actual, input longint expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference: a job is a plain ordered copy of n words.
    task automatic model_job(input logic dir, input int first, input int n);
        for (int i = 0; i < n; i++) begin
            if (dir == DIR_M2L) lstm_ref[i % LSTM_DEPTH] = mm_ref[(first + i) % MM_DEPTH];
            else                mm_ref[(first + i) % MM_DEPTH] = lstm_ref[i % LSTM_DEPTH];
        end
    endtask

    function automatic int mem_diffs();
        int d = 0;
        for (int i = 0; i < MM_DEPTH; i++)   if (mm_mem[i] !== mm_ref[i]) d++;
        for (int i = 0; i < LSTM_DEPTH; i++) if (lstm_mem[i] !== lstm_ref[i]) d++;
        return d;
    endfunction

    // Issues one job and observes it cycle by cycle (cycle 1 = first after accept).
    task automatic run_job(input logic dir, input int first, input int n, input int wr_stalls,
                           input bit rand_ready, input int intrude_at,
                           output int done_cyc, output int busy_cyc, output int stalls,
                           output int rd_lstm, output int viol);
        int budget;
        int c;
        budget = wr_stalls;
        done_cyc = -1; busy_cyc = 0; stalls = 0; rd_lstm = 0; viol = 0;
        addr_q.delete();
        @(negedge fpga_clk);
        start = 1'b1;
        direct = dir;
        main_mem_count = MW'(n);
        main_mem_first_address = MW'(first);
        @(negedge fpga_clk);
        start = 1'b0;
        c = 1;
        while (c <= 400 && done_cyc < 0) begin
            if (c == intrude_at) begin
                start = 1'b1;
                direct = ~dir;
                main_mem_count = MW'(1);
                main_mem_first_address = '0;
            end else begin
                start = 1'b0;
            end
            if (lstm_wr_en && budget > 0) begin
                lstm_ready = 1'b0;
                budget--;
            end else begin
                lstm_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if ((lstm_rd_en || lstm_wr_en) && !lstm_ready) stalls++;
            if (busy) busy_cyc++;
            if (done) done_cyc = c;
            if (lstm_rd_en && lstm_ready) rd_lstm++;
            if (mm_rd_en || mm_wr_en) addr_q.push_back(mm_addr);
            if ((mm_rd_en && mm_wr_en) || (lstm_rd_en && lstm_wr_en)) viol++;
            if (dir == DIR_M2L && (mm_wr_en || lstm_rd_en)) viol++;
            if (dir == DIR_L2M && (mm_rd_en || lstm_wr_en)) viol++;
            if (done && (busy || mm_rd_en || mm_wr_en || lstm_rd_en || lstm_wr_en)) viol++;
            @(negedge fpga_clk);
            c++;
        end
        start = 1'b0;
        lstm_ready = 1'b1;
        if (done_cyc < 0) $display("FAIL timeout: got no done, expected done within 400 cycles");
    endtask

    // Full check of one job against spec timing and the reference model.
    task automatic do_job(input string tag, input logic dir, input int first, input int n,
                          input int wr_stalls, input bit rand_ready, input int intrude_at);
        int dc, bc, st, rl, vi, bad;
        run_job(dir, first, n, wr_stalls, rand_ready, intrude_at, dc, bc, st, rl, vi);
        model_job(dir, first, n);
        bad = 0;
        if (addr_q.size() != n) bad++;
        else for (int i = 0; i < n; i++) if (addr_q[i] != MW'((first + i) % MM_DEPTH)) bad++;
        check({tag, " done_cycle"}, dc, 3 * n + 1 + st);
        check({tag, " busy_cycles"}, bc, 3 * n + st);
        check({tag, " lstm_reads"}, rl, (dir == DIR_L2M) ? n : 0);
        check({tag, " strobe_rules"}, vi, 0);
        check({tag, " mm_addr_seq"}, bad, 0);
        check({tag, " mem_diffs"}, mem_diffs(), 0);
        $display("[TB] %s dir=%0d first=%0d n=%0d stalls=%0d done@%0d busy=%0d",
                 tag, dir, first, n, st, dc, bc);
    endtask

    function automatic longint all_outputs();
        return {mm_addr, mm_rd_en, mm_wr_en, mm_wdata, lstm_addr, lstm_rd_en,
                lstm_wr_en, lstm_wdata, busy, done};
    endfunction

    typedef struct {
        logic dir;
        int   first;
        int   n;
        int   wr_stalls;
        int   intrude_at;
        int   exp_done;
        int   exp_busy;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int dc, bc, st, rl, vi;
        vecs[0] = '{DIR_L2M, 168,  4, 0, 0, 13, 12};
        vecs[1] = '{DIR_M2L, 40,   4, 0, 0, 13, 12};
        vecs[2] = '{DIR_M2L, 100,  2, 3, 0, 10, 9};
        vecs[3] = '{DIR_M2L, 5,    0, 0, 0, 1,  0};
        vecs[4] = '{DIR_M2L, 2046, 4, 0, 0, 13, 12};
        vecs[5] = '{DIR_M2L, 300,  4, 0, 5, 13, 12};

        for (int i = 0; i < MM_DEPTH; i++) begin
            mm_mem[i] = DW'($urandom);
            mm_ref[i] = mm_mem[i];
        end
        for (int i = 0; i < LSTM_DEPTH; i++) begin
            lstm_mem[i] = DW'($urandom);
            lstm_ref[i] = lstm_mem[i];
        end
        mm_mem[40] = 8'hA1; mm_mem[41] = 8'hB2; mm_mem[42] = 8'hC3; mm_mem[43] = 8'hD4;
        lstm_mem[0] = 8'h11; lstm_mem[1] = 8'h22; lstm_mem[2] = 8'h33; lstm_mem[3] = 8'h44;
        for (int i = 40; i < 44; i++) mm_ref[i] = mm_mem[i];
        for (int i = 0; i < 4; i++) lstm_ref[i] = lstm_mem[i];

        // Reset state.
        #12;
        check("reset outputs", all_outputs(), 0);
`ifdef LSTM_DMA_ERR_CHECK_EN
        check("reset err", err, 0);
`endif
        @(negedge fpga_clk);
        reset_n = 1'b1;

        // Directed table.
        for (int v = 0; v < 6; v++) begin
            run_job(vecs[v].dir, vecs[v].first, vecs[v].n, vecs[v].wr_stalls, 1'b0,
                    vecs[v].intrude_at, dc, bc, st, rl, vi);
            model_job(vecs[v].dir, vecs[v].first, vecs[v].n);
            check($sformatf("vec%0d done_cycle", v), dc, vecs[v].exp_done);
            check($sformatf("vec%0d busy_cycles", v), bc, vecs[v].exp_busy);
            check($sformatf("vec%0d strobe_rules", v), vi, 0);
            check($sformatf("vec%0d lstm_reads", v), rl, (vecs[v].dir == DIR_L2M) ? vecs[v].n : 0);
            check($sformatf("vec%0d mm_strobes", v), addr_q.size(), vecs[v].n);
            check($sformatf("vec%0d mem_diffs", v), mem_diffs(), 0);
            if (v == 0) check("l2m mm[168..171]", {mm_mem[168], mm_mem[169], mm_mem[170], mm_mem[171]}, 32'h11223344);
            if (v == 1) check("m2l lstm[0..3]", {lstm_mem[0], lstm_mem[1], lstm_mem[2], lstm_mem[3]}, 32'hA1B2C3D4);
            if (v == 4 && addr_q.size() == 4)
                check("wrap mm addrs", {addr_q[0], addr_q[1], addr_q[2], addr_q[3]},
                      {11'd2046, 11'd2047, 11'd0, 11'd1});
            $display("[TB] vec%0d dir=%0d first=%0d n=%0d done@%0d busy=%0d",
                     v, vecs[v].dir, vecs[v].first, vecs[v].n, dc, bc);
        end
`ifdef LSTM_DMA_ERR_CHECK_EN
        check("err after wrap/intrude", err, 1);
`endif

        // Abandon a job mid-transfer with reset, before any write lands.
        @(negedge fpga_clk);
        start = 1'b1; direct = DIR_M2L;
        main_mem_count = MW'(3); main_mem_first_address = MW'(500);
        @(negedge fpga_clk);
        start = 1'b0;
        @(negedge fpga_clk);
        reset_n = 1'b0;
        #1;
        check("mid reset outputs", all_outputs(), 0);
`ifdef LSTM_DMA_ERR_CHECK_EN
        check("mid reset err", err, 0);
`endif
        @(negedge fpga_clk);
        reset_n = 1'b1;
        $display("[TB] reset during transfer applied");
        do_job("post_reset", DIR_M2L, 500, 3, 0, 1'b0, 0);

        // Randomized jobs with random LSTM backpressure.
        for (int r = 0; r < 20; r++) begin
            do_job($sformatf("rand%0d", r), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, MM_DEPTH - 1)), int'($urandom_range(0, 10)),
                   0, 1'b1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
